l1_lc_request_arbiter: RTL and testbench

//  Sits between the L1 data cache's lower-cache port and the next-level cache. Buffers

---
 rtl/l1_lc_request_arbiter_pkg.sv | 10 +
 rtl/l1_lc_request_arbiter_lc_req_fifo.sv | 59 +++++
 rtl/l1_lc_request_arbiter.sv | 124 ++++++++++++
 tb/tb_l1_lc_request_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/l1_lc_request_arbiter_pkg.sv
// l1_lc_request_arbiter_pkg: shared request type and widths for the L1/LC request arbiter
package l1_lc_request_arbiter_pkg;
  localparam int PADDR_W = 22;
  localparam int DATA_W = 64;
  typedef struct packed {
    logic [PADDR_W-1:0] addr;
    logic [DATA_W-1:0]  data;
    logic               we;
  } lc_req_t;
endpackage

// File: rtl/l1_lc_request_arbiter_lc_req_fifo.sv
// lc_req_fifo: circular request FIFO exposing per-entry valid/contents for address matching
module lc_req_fifo
  import l1_lc_request_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T = lc_req_t,
  parameter bit COALESCE = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  T                         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_cw_en,
  input  logic [$clog2(DEPTH)-1:0] i_cw_idx,
  input  T                         i_cw_data,
  output T                         o_head,
  output logic [$clog2(DEPTH)-1:0] o_head_idx,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [DEPTH-1:0]         o_vld,
  output T                         o_mem [DEPTH]
);
  localparam int AW = $clog2(DEPTH);
  T r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_head = r_mem[r_rp];
  assign o_head_idx = r_rp;
  assign o_mem = r_mem;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  for (genvar g = 0; g < DEPTH; g++) begin : g_vld
    logic [AW-1:0] w_off;
    assign w_off = AW'(g) - r_rp;
    assign o_vld[g] = {1'b0, w_off} < r_cnt;
  end
  // pointers wrap modulo DEPTH; count tracks occupancy
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  // storage: coalesce rewrites a live entry, push fills the free slot at the write pointer
  always_ff @(posedge i_clk) begin
    if (COALESCE && i_cw_en) r_mem[i_cw_idx] <= i_cw_data;
    if (w_push) r_mem[r_wp] <= i_push_data;
  end
endmodule

// File: rtl/l1_lc_request_arbiter.sv
// l1_lc_request_arbiter: queues L1 miss reads and writebacks onto one lc port, returns fills
module l1_lc_request_arbiter
  import l1_lc_request_arbiter_pkg::*;
#(
  parameter int PADDR_BITS = PADDR_W,
  parameter int DATA_BITS = DATA_W,
  parameter int RD_DEPTH = 4,
  parameter int WB_DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  l1_valid_in,
  output logic                  l1_ready_out,
  input  logic [PADDR_BITS-1:0] l1_addr_in,
  input  logic [DATA_BITS-1:0]  l1_value_in,
  input  logic                  l1_we_in,
  output logic                  l1_valid_out,
  input  logic                  l1_ready_in,
  output logic [PADDR_BITS-1:0] l1_addr_out,
  output logic [DATA_BITS-1:0]  l1_value_out,
  output logic                  lc_valid_out,
  input  logic                  lc_ready_in,
  output logic [PADDR_BITS-1:0] lc_addr_out,
  output logic [DATA_BITS-1:0]  lc_value_out,
  output logic                  lc_we_out,
  input  logic                  lc_valid_in,
  output logic                  lc_ready_out,
  input  logic [PADDR_BITS-1:0] lc_addr_in,
  input  logic [DATA_BITS-1:0]  lc_value_in,
  output logic                  idle_out
);
  localparam int RAW = $clog2(RD_DEPTH);
  localparam int WAW = $clog2(WB_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  lc_req_t w_in, w_rd_head, w_wb_head, r_req;
  lc_req_t w_wb_mem [WB_DEPTH];
  lc_req_t w_rd_mem_unused [RD_DEPTH];
  logic [RD_DEPTH-1:0] w_rd_vld_unused;
  logic [WB_DEPTH-1:0] w_wb_vld;
  logic [RAW-1:0] w_rd_idx_unused;
  logic [WAW-1:0] w_wb_head_idx, w_wb_hit_idx;
  logic [RAW:0] w_rd_cnt;
  logic [WAW:0] w_wb_cnt;
  logic [SW-1:0] r_starve;
  logic w_rd_full_unused, w_rd_empty, w_wb_full, w_wb_empty;
  logic w_accept, w_wb_hit, w_rd_hazard, w_load, w_issue, w_sel_wb, w_rd_pop, w_wb_pop;
  logic r_valid, r_fvalid;
  logic [PADDR_BITS-1:0] r_faddr;
  logic [DATA_BITS-1:0] r_fdata;
  assign w_in = '{addr: l1_addr_in, data: l1_value_in, we: l1_we_in};
  assign l1_ready_out = (w_rd_cnt != (RAW+1)'(RD_DEPTH)) && (w_wb_cnt != (WAW+1)'(WB_DEPTH));
  assign w_accept = l1_valid_in && l1_ready_out;
  lc_req_fifo #(.DEPTH(RD_DEPTH), .T(lc_req_t), .COALESCE(1'b0)) u_rd (
    .i_clk(clk_in), .i_rst(rst_in),
    .i_push(w_accept && !l1_we_in), .i_push_data(w_in), .i_pop(w_rd_pop),
    .i_cw_en(1'b0), .i_cw_idx('0), .i_cw_data('0),
    .o_head(w_rd_head), .o_head_idx(w_rd_idx_unused), .o_full(w_rd_full_unused),
    .o_empty(w_rd_empty), .o_count(w_rd_cnt), .o_vld(w_rd_vld_unused), .o_mem(w_rd_mem_unused)
  );
  lc_req_fifo #(.DEPTH(WB_DEPTH), .T(lc_req_t), .COALESCE(1'b1)) u_wb (
    .i_clk(clk_in), .i_rst(rst_in),
    .i_push(w_accept && l1_we_in && !w_wb_hit), .i_push_data(w_in), .i_pop(w_wb_pop),
    .i_cw_en(w_accept && l1_we_in && w_wb_hit), .i_cw_idx(w_wb_hit_idx), .i_cw_data(w_in),
    .o_head(w_wb_head), .o_head_idx(w_wb_head_idx), .o_full(w_wb_full),
    .o_empty(w_wb_empty), .o_count(w_wb_cnt), .o_vld(w_wb_vld), .o_mem(w_wb_mem)
  );
  // incoming writeback coalesce match; the entry leaving this cycle cannot absorb new data
  always_comb begin
    w_wb_hit = 1'b0;
    w_wb_hit_idx = '0;
    for (int i = 0; i < WB_DEPTH; i++)
      if (w_wb_vld[i] && w_wb_mem[i].addr == l1_addr_in && !(w_wb_pop && WAW'(i) == w_wb_head_idx)) begin
        w_wb_hit = 1'b1;
        w_wb_hit_idx = WAW'(i);
      end
  end
  // RD head must wait behind any buffered writeback to the same line
  always_comb begin
    w_rd_hazard = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++)
      if (w_wb_vld[i] && w_wb_mem[i].addr == w_rd_head.addr) w_rd_hazard = 1'b1;
  end
  assign w_load = !r_valid || lc_ready_in;
  assign w_issue = w_load && !(w_rd_empty && w_wb_empty);
  assign w_sel_wb = w_wb_full || (!w_rd_empty && w_rd_hazard) ||
                    (r_starve == SW'(STARVE_LIMIT) && !w_wb_empty) || w_rd_empty;
  assign w_wb_pop = w_issue && w_sel_wb;
  assign w_rd_pop = w_issue && !w_sel_wb;
  // count reads issued past a waiting writeback, saturating at the limit
  always_ff @(posedge clk_in)
    if (rst_in) r_starve <= '0;
    else r_starve <= (w_wb_empty || w_wb_pop) ? '0 :
                     (w_rd_pop && r_starve != SW'(STARVE_LIMIT)) ? r_starve + SW'(1) : r_starve;
  // lc request register, held while the lower cache stalls
  always_ff @(posedge clk_in)
    if (rst_in) begin
      r_valid <= 1'b0;
      r_req <= '0;
    end else if (w_load) begin
      r_valid <= w_issue;
      if (w_issue) r_req <= w_sel_wb ? w_wb_head : w_rd_head;
    end
  assign lc_valid_out = r_valid;
  assign lc_addr_out = r_req.addr;
  assign lc_value_out = r_req.data;
  assign lc_we_out = r_req.we;
  assign idle_out = w_rd_empty && w_wb_empty && !r_valid;
  assign lc_ready_out = !r_fvalid || l1_ready_in;
  // one-entry fill register toward L1
  always_ff @(posedge clk_in)
    if (rst_in) begin
      r_fvalid <= 1'b0;
      r_faddr <= '0;
      r_fdata <= '0;
    end else if (lc_valid_in && lc_ready_out) begin
      r_fvalid <= 1'b1;
      r_faddr <= lc_addr_in;
      r_fdata <= lc_value_in;
    end else if (l1_ready_in) r_fvalid <= 1'b0;
  assign l1_valid_out = r_fvalid;
  assign l1_addr_out = r_faddr;
  assign l1_value_out = r_fdata;
endmodule

// File: tb/tb_l1_lc_request_arbiter.sv
// tb_l1_lc_request_arbiter: directed checks of queueing, ordering, coalescing, starvation and fill path
module tb_l1_lc_request_arbiter;
  import l1_lc_request_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst_in, l1_valid_in, l1_ready_out, l1_we_in, l1_valid_out, l1_ready_in;
  logic lc_valid_out, lc_ready_in, lc_we_out, lc_valid_in, lc_ready_out, idle_out;
  logic [21:0] l1_addr_in, l1_addr_out, lc_addr_out, lc_addr_in;
  logic [63:0] l1_value_in, l1_value_out, lc_value_out, lc_value_in;
  int n_chk = 0;
  int n_fail = 0;
  lc_req_t got [$];

  l1_lc_request_arbiter dut (
    .clk_in(clk), .rst_in(rst_in),
    .l1_valid_in(l1_valid_in), .l1_ready_out(l1_ready_out), .l1_addr_in(l1_addr_in),
    .l1_value_in(l1_value_in), .l1_we_in(l1_we_in),
    .l1_valid_out(l1_valid_out), .l1_ready_in(l1_ready_in), .l1_addr_out(l1_addr_out),
    .l1_value_out(l1_value_out),
    .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in), .lc_addr_out(lc_addr_out),
    .lc_value_out(lc_value_out), .lc_we_out(lc_we_out),
    .lc_valid_in(lc_valid_in), .lc_ready_out(lc_ready_out), .lc_addr_in(lc_addr_in),
    .lc_value_in(lc_value_in), .idle_out(idle_out)
  );

  always #5 clk = ~clk;

  // record every lc handshake; inputs only change on negedges, so this sees the values of the next posedge
  always @(negedge clk) begin
    #1;
    if (rst_in === 1'b0 && lc_valid_out && lc_ready_in)
      got.push_back('{addr: lc_addr_out, data: lc_value_out, we: lc_we_out});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_lc(input string tag, input int i, input logic we, input logic [21:0] a, input logic [63:0] d);
    lc_req_t g;
    g = '0;
    if (i < got.size()) g = got[i];
    n_chk++;
    assert (g.we === we && g.addr === a && (!we || g.data === d)) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h",
             tag, i, g.we, g.addr, g.data, we, a, d);
    end
  endtask

  task automatic send(input logic we, input logic [21:0] a, input logic [63:0] d);
    int n = 0;
    l1_valid_in = 1'b1;
    l1_we_in = we;
    l1_addr_in = a;
    l1_value_in = d;
    while (!l1_ready_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'(l1_ready_out), 64'd1);
    @(negedge clk);
    l1_valid_in = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    lc_ready_in = 1'b1;
    while (!idle_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(idle_out), 64'd1);
    lc_ready_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    l1_valid_in = 1'b1;
    l1_we_in = 1'b0;
    l1_addr_in = 22'h5;
    l1_value_in = '0;
    l1_ready_in = 1'b1;
    lc_ready_in = 1'b0;
    lc_valid_in = 1'b0;
    lc_addr_in = '0;
    lc_value_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_lc_valid", 64'(lc_valid_out), 64'd0);
    chk("rst_l1_valid", 64'(l1_valid_out), 64'd0);
    rst_in = 1'b0;
    l1_valid_in = 1'b0;
    chk("rst_l1_ready", 64'(l1_ready_out), 64'd1);
    chk("rst_idle", 64'(idle_out), 64'd1);
    chk("rst_lc_ready", 64'(lc_ready_out), 64'd1);
    chk("rst_lc_addr", 64'(lc_addr_out), 64'd0);
    chk("rst_lc_we", 64'(lc_we_out), 64'd0);
    chk("rst_l1_addr", 64'(l1_addr_out), 64'd0);
    repeat (3) @(negedge clk);
    chk("rst_nothing_queued", 64'(lc_valid_out), 64'd0);
    chk("rst_still_idle", 64'(idle_out), 64'd1);

    send(1'b1, 22'h100, 64'hAA);
    send(1'b0, 22'h200, 64'h0);
    chk("t2_out_valid", 64'(lc_valid_out), 64'd1);
    chk("t2_out_we", 64'(lc_we_out), 64'd1);
    chk("t2_out_addr", 64'(lc_addr_out), 64'h100);
    chk("t2_out_value", lc_value_out, 64'hAA);
    chk("t2_busy", 64'(idle_out), 64'd0);
    drain("t2_drain");
    chk("t2_count", 64'(got.size()), 64'd2);
    chk_lc("t2", 0, 1'b1, 22'h100, 64'hAA);
    chk_lc("t2", 1, 1'b0, 22'h200, 64'h0);
    got.delete();

    send(1'b1, 22'h300, 64'hBB);
    send(1'b1, 22'h104, 64'hCC);
    send(1'b0, 22'h204, 64'h0);
    drain("t2b_drain");
    chk("t2b_count", 64'(got.size()), 64'd3);
    chk_lc("t2b", 0, 1'b1, 22'h300, 64'hBB);
    chk_lc("t2b", 1, 1'b0, 22'h204, 64'h0);
    chk_lc("t2b", 2, 1'b1, 22'h104, 64'hCC);
    got.delete();

    send(1'b1, 22'h500, 64'h1);
    send(1'b1, 22'h100, 64'h11);
    send(1'b0, 22'h100, 64'h0);
    drain("t3_drain");
    chk("t3_count", 64'(got.size()), 64'd3);
    chk_lc("t3", 0, 1'b1, 22'h500, 64'h1);
    chk_lc("t3", 1, 1'b1, 22'h100, 64'h11);
    chk_lc("t3", 2, 1'b0, 22'h100, 64'h0);
    got.delete();

    send(1'b1, 22'h600, 64'h5);
    send(1'b1, 22'h40, 64'h1);
    send(1'b1, 22'h40, 64'h2);
    chk("t4_ready", 64'(l1_ready_out), 64'd1);
    drain("t4_drain");
    chk("t4_count", 64'(got.size()), 64'd2);
    chk_lc("t4", 0, 1'b1, 22'h600, 64'h5);
    chk_lc("t4", 1, 1'b1, 22'h40, 64'h2);
    got.delete();

    send(1'b1, 22'h0, 64'h10);
    send(1'b0, 22'h7, 64'h0);
    for (int i = 1; i <= 4; i++) send(1'b1, 22'(i), 64'(16 + i));
    chk("t5_wb_full_ready", 64'(l1_ready_out), 64'd0);
    l1_valid_in = 1'b1;
    l1_we_in = 1'b0;
    l1_addr_in = 22'h9;
    repeat (2) @(negedge clk);
    l1_valid_in = 1'b0;
    chk("t5_still_blocked", 64'(l1_ready_out), 64'd0);
    drain("t5_drain");
    chk("t5_count", 64'(got.size()), 64'd6);
    chk_lc("t5", 0, 1'b1, 22'h0, 64'h10);
    chk_lc("t5", 1, 1'b1, 22'h1, 64'h11);
    chk_lc("t5", 2, 1'b0, 22'h7, 64'h0);
    chk_lc("t5", 3, 1'b1, 22'h2, 64'h12);
    chk_lc("t5", 4, 1'b1, 22'h3, 64'h13);
    chk_lc("t5", 5, 1'b1, 22'h4, 64'h14);
    got.delete();

    send(1'b1, 22'hA00, 64'h77);
    send(1'b1, 22'hB00, 64'h88);
    for (int i = 1; i <= 4; i++) send(1'b0, 22'hC00 + 22'(i), 64'h0);
    lc_ready_in = 1'b1;
    for (int i = 5; i <= 10; i++) send(1'b0, 22'hC00 + 22'(i), 64'h0);
    drain("t6_drain");
    chk("t6_count", 64'(got.size()), 64'd12);
    chk_lc("t6", 0, 1'b1, 22'hA00, 64'h77);
    for (int i = 1; i <= 8; i++) chk_lc("t6", i, 1'b0, 22'hC00 + 22'(i), 64'h0);
    chk_lc("t6", 9, 1'b1, 22'hB00, 64'h88);
    chk_lc("t6", 10, 1'b0, 22'hC09, 64'h0);
    chk_lc("t6", 11, 1'b0, 22'hC0A, 64'h0);
    got.delete();

    l1_ready_in = 1'b0;
    lc_valid_in = 1'b1;
    lc_addr_in = 22'h80;
    lc_value_in = 64'hDEAD;
    #1;
    chk("t7_ready_empty", 64'(lc_ready_out), 64'd1);
    @(negedge clk);
    chk("t7_fill_valid", 64'(l1_valid_out), 64'd1);
    chk("t7_fill_addr", 64'(l1_addr_out), 64'h80);
    chk("t7_fill_value", l1_value_out, 64'hDEAD);
    chk("t7_blocked", 64'(lc_ready_out), 64'd0);
    lc_addr_in = 22'h81;
    lc_value_in = 64'hBEEF;
    repeat (2) @(negedge clk);
    chk("t7_hold_valid", 64'(l1_valid_out), 64'd1);
    chk("t7_hold_addr", 64'(l1_addr_out), 64'h80);
    chk("t7_hold_value", l1_value_out, 64'hDEAD);
    l1_ready_in = 1'b1;
    #1;
    chk("t7_ready_pass", 64'(lc_ready_out), 64'd1);
    @(negedge clk);
    chk("t7_next_valid", 64'(l1_valid_out), 64'd1);
    chk("t7_next_addr", 64'(l1_addr_out), 64'h81);
    chk("t7_next_value", l1_value_out, 64'hBEEF);
    lc_valid_in = 1'b0;
    @(negedge clk);
    chk("t7_done_valid", 64'(l1_valid_out), 64'd0);
    chk("t7_done_ready", 64'(lc_ready_out), 64'd1);

    send(1'b1, 22'h700, 64'h3);
    send(1'b0, 22'h701, 64'h0);
    chk("t8_pending", 64'(lc_valid_out), 64'd1);
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    chk("t8_idle", 64'(idle_out), 64'd1);
    chk("t8_lc_valid", 64'(lc_valid_out), 64'd0);
    chk("t8_l1_ready", 64'(l1_ready_out), 64'd1);
    lc_ready_in = 1'b1;
    repeat (4) @(negedge clk);
    lc_ready_in = 1'b0;
    chk("t8_dropped", 64'(got.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
